// File: rtl/aes_round_key_server_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_key_server_if
//  Brief    : Round-key delivery channel between key server and round datapath.
//  Revision : 1.0
// ============================================================================
interface aes_round_key_server_if #(
    parameter int KEY_W = 128
);
    logic [KEY_W-1:0] round_key;
    logic             key_valid;
    logic [3:0]       round_num;
    logic             last_key;
    logic             key_ready;

    modport master (
        output round_key,
        output key_valid,
        output round_num,
        output last_key,
        input  key_ready
    );

    modport slave (
        input  round_key,
        input  key_valid,
        input  round_num,
        input  last_key,
        output key_ready
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_key_server.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_key_server
//  Brief    : Latches the AES-128 round-key set and serves it one key per round.
//  Revision : 1.0
// ============================================================================
module aes_round_key_server #(
    parameter int NUM_KEYS = 11,
    parameter int KEY_W    = 128
) (
    input  wire logic                      clk,
    input  wire logic                      n_rst,
    input  wire logic [NUM_KEYS*KEY_W-1:0] roundKeys,
    input  wire logic                      keys_done,
    input  wire logic                      start,
    input  wire logic                      decrypt,
    input  wire logic                      abort,
    aes_round_key_server_if.master         key_if,
    output logic                           busy,
    output logic                           seq_done,
    output logic                           start_err
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SERVE = 1'b1;
    localparam logic [3:0] c_LAST_IDX = 4'(NUM_KEYS - 1);

    logic [KEY_W-1:0] w_keys  [NUM_KEYS];
    logic [KEY_W-1:0] r_store [NUM_KEYS];

    logic [0:0]       r_state;
    logic             r_decrypt;
    logic [3:0]       r_index;
    logic [KEY_W-1:0] r_round_key;
    logic             r_key_valid;
    logic             r_last_key;
    logic             r_busy;
    logic             r_seq_done;
    logic             r_start_err;

    logic [3:0]       w_next_idx;
    logic [3:0]       w_final_idx;
    logic             w_xfer;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_unpack
        assign w_keys[gi] = roundKeys[gi*KEY_W +: KEY_W];
    end

    // w_next_idx is only consumed on non-last transfers, so it never leaves 0..10
    assign w_next_idx  = r_decrypt ? (r_index - 4'd1) : (r_index + 4'd1);
    assign w_final_idx = r_decrypt ? 4'd0 : c_LAST_IDX;
    assign w_xfer      = r_key_valid && key_if.key_ready;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= c_ST_IDLE;
            r_decrypt   <= 1'b0;
            r_index     <= 4'd0;
            r_round_key <= '0;
            r_key_valid <= 1'b0;
            r_last_key  <= 1'b0;
            r_busy      <= 1'b0;
            r_seq_done  <= 1'b0;
            r_start_err <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_store[i] <= '0;
            end
        end else begin
            r_seq_done  <= 1'b0;
            r_start_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // abort in IDLE silently swallows a coincident start
                    if (start && !abort) begin
                        if (keys_done) begin
                            r_store     <= w_keys;
                            r_decrypt   <= decrypt;
                            r_index     <= decrypt ? c_LAST_IDX : 4'd0;
                            r_round_key <= decrypt ? w_keys[NUM_KEYS-1] : w_keys[0];
                            r_key_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_last_key  <= 1'b0;
                            r_state     <= c_ST_SERVE;
                        end else begin
                            r_start_err <= 1'b1;
                        end
                    end
                end
                c_ST_SERVE: begin
                    if (abort) begin
                        r_key_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_last_key  <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end else if (w_xfer) begin
                        if (r_last_key) begin
                            r_key_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_last_key  <= 1'b0;
                            r_seq_done  <= 1'b1;
                            r_state     <= c_ST_IDLE;
                        end else begin
                            r_index     <= w_next_idx;
                            r_round_key <= r_store[w_next_idx];
                            r_last_key  <= (w_next_idx == w_final_idx);
                        end
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_key_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_last_key  <= 1'b0;
                end
            endcase
        end
    end

    assign key_if.round_key = r_round_key;
    assign key_if.key_valid = r_key_valid;
    assign key_if.round_num = r_index;
    assign key_if.last_key  = r_last_key;
    assign busy             = r_busy;
    assign seq_done         = r_seq_done;
    assign start_err        = r_start_err;

endmodule
`default_nettype wire

// File: doc/aes_round_key_server.md
# aes_round_key_server

Buffers the 11 AES-128 round keys produced by the key schedule and serves them one per round to the cipher round datapath over a valid/ready handshake. It serves keys in ascending order (0..10) for encryption and descending order (10..0) for decryption. The whole key set is latched at sequence start, so the key schedule input may change mid-sequence without corrupting the keys being served.

## Interface
Parameters:
- NUM_KEYS, 11, number of round keys (fixed for AES-128; not overridden)
- KEY_W, 128, width of one round key

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  synchronous, active-low reset
- roundKeys  input  1408  packed key set; key i occupies [128*i+127 : 128*i]
- keys_done  input  1  key schedule output valid; must be 1 for a start to be accepted
- start  input  1  request a new key sequence; sampled only in IDLE
- decrypt  input  1  direction, sampled with an accepted start: 0 gives 0..10, 1 gives 10..0
- abort  input  1  terminate the current sequence
- key_ready  input  1  round datapath accepts round_key this cycle
- round_key  output  128  current round key
- key_valid  output  1  round_key and round_num are valid
- round_num  output  4  index (0..10) of the key on round_key
- last_key  output  1  high with key_valid when round_key is the final key of the sequence
- busy  output  1  high in SERVE
- seq_done  output  1  one-cycle pulse after the last key is accepted
- start_err  output  1  one-cycle pulse when start is rejected (keys_done low)

## Operation
- States: IDLE and SERVE. All outputs are registered.
- In IDLE, with start=1 and keys_done=1:
  - latch all 1408 bits of roundKeys into an internal store
  - latch decrypt
  - load the index with 0 (encrypt) or 10 (decrypt)
  - go to SERVE
- In IDLE, with start=1 and keys_done=0: pulse start_err, stay in IDLE, leave the store unchanged.
- In SERVE:
  - key_valid=1, busy=1, round_key = store[index], round_num = index.
  - last_key=1 when index=10 (encrypt) or index=0 (decrypt).
- Handshake: a transfer occurs on a clock edge where key_valid=1 and key_ready=1. round_key, round_num and last_key hold stable while key_valid=1 and key_ready=0.
- On a non-last transfer, the index steps +1 (encrypt) or −1 (decrypt). The index never wraps; it stays within 0..10.
- On the last transfer: go to IDLE; key_valid, busy and last_key drop; seq_done pulses for one cycle.
- start while in SERVE is ignored; no error is flagged.
- abort in SERVE:
  - go to IDLE next cycle, with key_valid=0 and busy=0
  - seq_done does not pulse
  - abort takes priority over a simultaneous transfer
- abort in IDLE has no effect. abort together with start in IDLE gives priority to abort, and the start is dropped.
- Changes on roundKeys, keys_done or decrypt during SERVE have no effect on the sequence in progress.
- In IDLE, round_key and round_num hold their last values, but only key_valid qualifies them.

## Timing
- Reset (n_rst=0 at a rising edge):
  - state IDLE; store cleared to 0
  - round_key=0, round_num=0
  - key_valid, last_key, busy, seq_done and start_err all 0
- Reset overrides every other input, including mid-sequence; no seq_done is produced.
- Start latency: start is accepted at edge T; key_valid=1 with the first key from edge T+1.
- Throughput: one key per cycle while key_ready=1. A full sequence with key_ready held high spans 11 cycles of key_valid; seq_done is high in the cycle after the last valid cycle.
- start_err is high for exactly the one cycle after the rejected start edge.
- Back-to-back sequences: a new start is accepted no earlier than the cycle in which seq_done is high. That is the first IDLE cycle, so there is 1 idle cycle minimum between sequences.
- After abort at edge T, key_valid=0 from T+1, and a new start is accepted at edge T+1.

## Test plan
- Encrypt, continuous: set roundKeys key i = {16{8'(i)}}, keys_done=1, start with decrypt=0, key_ready=1 -> round_num 0..10 on consecutive cycles, round_key 128'h00..00 to 128'h0a0a..0a, last_key only with round_num=10, then a single seq_done pulse.
- Decrypt with stalls: same keys, decrypt=1, key_ready toggled 1,0,0,1,... -> order 10..0, no key skipped or repeated, outputs stable during stalls, last_key with round_num=0.
- Key isolation: after start, overwrite roundKeys with all-ones and drop keys_done -> all 11 served keys still match the original pattern.
- Rejected start: keys_done=0, start=1 -> start_err for one cycle, key_valid stays 0, busy stays 0.
- Abort and reset mid-sequence:
  - abort at round_num=4 with key_ready=1 -> key_valid=0 next cycle, no seq_done, a new start succeeds immediately
  - n_rst=0 at round_num=7 -> all outputs 0, no seq_done
- Ignored restart: start=1 with decrypt=1 asserted during an encrypt sequence -> sequence continues 0..10 unchanged, no start_err.
